// File: rtl/mm_pkg.sv
// Definitions shared by the input loader and the matrix-multiply controller:
// default memory sizes, counter width and the loader state encoding.
`timescale 1ns/1ps
package mm_pkg;

  localparam int unsigned A_DEPTH_DEF = 1024;
  localparam int unsigned B_WORDS_DEF = 256;
  localparam int unsigned CNT_W       = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT_MM
  } mm_state_e;

  function automatic logic is_loading(mm_state_e s);
    return (s == LOAD_A) || (s == LOAD_B);
  endfunction

endpackage

// File: rtl/mm_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; the top supplies the lane
// (low two counter bits) so only one byte counter exists in the loader.
`timescale 1ns/1ps
module mm_byte_packer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  // Holds bytes 0..2 of the word in progress; byte 0 ends up in the low lane.
  logic [23:0] pack_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pack_q <= '0;
    end else if (clear) begin
      pack_q <= '0;
    end else if (byte_en) begin
      pack_q <= {byte_in, pack_q[23:8]};
    end
  end

  assign word      = {byte_in, pack_q};
  assign word_done = byte_en && (lane == 2'd3);

endmodule

// File: rtl/mm_input_loader.sv
// Streams A bytes then packed B words into the operand memories, kicks off the
// matrix-multiply controller and waits for it to finish.
`timescale 1ns/1ps
module mm_input_loader
  import mm_pkg::*;
#(
  parameter int unsigned A_DEPTH = A_DEPTH_DEF,
  parameter int unsigned B_WORDS = B_WORDS_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load_req,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [9:0]  address_a,
  output logic [7:0]  A_in,
  output logic        nce_a,
  output logic        nwrt_a,
  output logic [7:0]  address_b,
  output logic [31:0] B_in,
  output logic        nce_b,
  output logic        nwrt_b,
  output logic        start,
  input  logic        mm_done,
  output logic        busy,
  output logic        load_done
);

  localparam logic [CNT_W-1:0] ALast = CNT_W'(A_DEPTH - 1);
  localparam logic [CNT_W-1:0] BLast = CNT_W'(4 * B_WORDS - 1);

  mm_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             beat;
  logic             pack_clear;
  logic             pack_en;
  logic [31:0]      pack_word;
  logic             pack_done;

  assign beat       = in_valid && in_ready;
  assign pack_clear = (state_q == IDLE) && load_req;
  assign pack_en    = beat && (state_q == LOAD_B);

  mm_byte_packer u_packer (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (pack_clear),
    .byte_en   (pack_en),
    .lane      (cnt_q[1:0]),
    .byte_in   (in_data),
    .word      (pack_word),
    .word_done (pack_done)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      start     <= 1'b0;
      load_done <= 1'b0;
      nce_a     <= 1'b1;
      nwrt_a    <= 1'b1;
      nce_b     <= 1'b1;
      nwrt_b    <= 1'b1;
      address_a <= '0;
      A_in      <= '0;
      address_b <= '0;
      B_in      <= '0;
    end else begin
      // Strobes and pulses are single-cycle; addresses and data hold.
      nce_a     <= 1'b1;
      nwrt_a    <= 1'b1;
      nce_b     <= 1'b1;
      nwrt_b    <= 1'b1;
      start     <= 1'b0;
      load_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_req) begin
            state_q  <= LOAD_A;
            cnt_q    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD_A: begin
          if (beat) begin
            nce_a     <= 1'b0;
            nwrt_a    <= 1'b0;
            address_a <= cnt_q;
            A_in      <= in_data;
            if (cnt_q == ALast) begin
              cnt_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (beat) begin
            if (pack_done) begin
              nce_b     <= 1'b0;
              nwrt_b    <= 1'b0;
              address_b <= cnt_q[CNT_W-1:2];
              B_in      <= pack_word;
            end
            if (cnt_q == BLast) begin
              cnt_q    <= '0;
              state_q  <= START;
              in_ready <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        // One spare cycle so start lands right after the last B strobe.
        START: begin
          start   <= 1'b1;
          state_q <= WAIT_MM;
        end
        WAIT_MM: begin
          if (mm_done) begin
            load_done <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_input_loader.sv
// Directed bench for mm_input_loader: full loads with and without bubbles,
// stray control pulses, and reset in the middle of a load.
`timescale 1ns/1ps
module tb_mm_input_loader;

  localparam int A_DEPTH = 1024;
  localparam int B_WORDS = 256;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        load_req = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [9:0]  address_a;
  logic [7:0]  A_in;
  logic        nce_a, nwrt_a;
  logic [7:0]  address_b;
  logic [31:0] B_in;
  logic        nce_b, nwrt_b;
  logic        start;
  logic        mm_done = 1'b0;
  logic        busy;
  logic        load_done;

  mm_input_loader dut (
    .clk       (clk),
    .nrst      (nrst),
    .load_req  (load_req),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .address_a (address_a),
    .A_in      (A_in),
    .nce_a     (nce_a),
    .nwrt_a    (nwrt_a),
    .address_b (address_b),
    .B_in      (B_in),
    .nce_b     (nce_b),
    .nwrt_b    (nwrt_b),
    .start     (start),
    .mm_done   (mm_done),
    .busy      (busy),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [17:0] qa[$];
  logic [39:0] qb[$];
  int a_cnt = 0, b_cnt = 0, start_cnt = 0, ld_cnt = 0;
  int cyc = 0, last_b_cyc = -10;
  logic [7:0]  last_b_addr = '0;
  logic [31:0] b_word0 = '0, b_word255 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe pops and compares one expected write.
  always @(negedge clk) begin
    logic [17:0] ea;
    logic [39:0] eb;
    cyc++;
    if (nrst) begin
      if (!nce_a || !nwrt_a) begin
        chk("a_strobe_pair", {30'd0, nce_a, nwrt_a}, 32'd0);
        a_cnt++;
        if (qa.size() == 0) chk("a_unexpected_write", a_cnt, 0);
        else begin
          ea = qa.pop_front();
          chk("a_addr", {22'd0, address_a}, {22'd0, ea[17:8]});
          chk("a_data", {24'd0, A_in}, {24'd0, ea[7:0]});
        end
      end
      if (!nce_b || !nwrt_b) begin
        chk("b_strobe_pair", {30'd0, nce_b, nwrt_b}, 32'd0);
        chk("b_after_all_a", a_cnt, A_DEPTH);
        b_cnt++;
        if (qb.size() == 0) chk("b_unexpected_write", b_cnt, 0);
        else begin
          eb = qb.pop_front();
          chk("b_addr", {24'd0, address_b}, {24'd0, eb[39:32]});
          chk("b_data", B_in, eb[31:0]);
        end
        if (address_b == 8'd0) b_word0 = B_in;
        if (address_b == 8'd255) b_word255 = B_in;
        last_b_cyc  = cyc;
        last_b_addr = address_b;
      end
      if (start) begin
        start_cnt++;
        chk("start_after_last_b", cyc - last_b_cyc, 1);
        chk("start_last_b_addr", {24'd0, last_b_addr}, 32'd255);
      end
      if (load_done) ld_cnt++;
    end
  end

  task automatic clear_counts();
    qa.delete();
    qb.delete();
    a_cnt = 0; b_cnt = 0; start_cnt = 0; ld_cnt = 0;
    b_word0 = '0; b_word255 = '0;
  endtask

  // Streams n_beats bytes (value = index mod 256); gaps toggles in_valid 1,0.
  task automatic send_load(input bit gaps, input bit poke, input int n_beats);
    int i, j, lane, guard;
    bit acc;
    logic [31:0] w;
    w = '0;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    i = 0; guard = 0;
    while (i < n_beats && guard < 20000) begin
      in_valid = gaps ? (guard % 2 == 0) : 1'b1;
      in_data  = i[7:0];
      if (poke && i == 1500) begin
        load_req = 1'b1;
        mm_done  = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        if (i < A_DEPTH) qa.push_back({i[9:0], i[7:0]});
        else begin
          j = i - A_DEPTH;
          lane = j % 4;
          w[8*lane +: 8] = i[7:0];
          if (lane == 3) qb.push_back({j[9:2], w});
        end
      end
      @(posedge clk); #1;
      load_req = 1'b0;
      mm_done  = 1'b0;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 20000) chk("load_timeout", i, n_beats);
  endtask

  task automatic finish_mm(input int delay);
    int g;
    g = 0;
    while (start !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("start_seen", {31'd0, start}, 32'd1);
    chk("busy_at_start", {31'd0, busy}, 32'd1);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("busy_wait_mm", {31'd0, busy}, 32'd1);
      chk("no_done_early", {31'd0, load_done}, 32'd0);
    end
    @(posedge clk); #1;
    mm_done = 1'b1;
    @(posedge clk); #1;
    mm_done = 1'b0;
    @(negedge clk);
    chk("load_done_pulse", {31'd0, load_done}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("load_done_one_cycle", {31'd0, load_done}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic end_of_load_checks();
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    chk("a_write_count", a_cnt, A_DEPTH);
    chk("b_write_count", b_cnt, B_WORDS);
    chk("start_count", start_cnt, 1);
    chk("load_done_count", ld_cnt, 1);
    chk("b_word0", b_word0, 32'h0302_0100);
    chk("b_word255", b_word255, 32'hFFFE_FDFC);
  endtask

  task automatic reset_value_checks(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_start"}, {31'd0, start}, 32'd0);
    chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_nce_nwrt"}, {28'd0, nce_a, nwrt_a, nce_b, nwrt_b}, 32'hF);
    chk({tag, "_address_a"}, {22'd0, address_a}, 32'd0);
    chk({tag, "_A_in"}, {24'd0, A_in}, 32'd0);
    chk({tag, "_address_b"}, {24'd0, address_b}, 32'd0);
    chk({tag, "_B_in"}, B_in, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset_value_checks("rst");
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    reset_value_checks("post_rst");

    // Full load, no bubbles, 50-cycle multiply
    clear_counts();
    send_load(1'b0, 1'b0, 4 * B_WORDS + A_DEPTH);
    finish_mm(50);
    end_of_load_checks();

    // Full load with in_valid toggling every cycle
    clear_counts();
    send_load(1'b1, 1'b0, 4 * B_WORDS + A_DEPTH);
    finish_mm(3);
    end_of_load_checks();

    // Stray load_req / mm_done during LOAD_B
    clear_counts();
    send_load(1'b0, 1'b1, 4 * B_WORDS + A_DEPTH);
    chk("poke_no_start_yet", start_cnt, 0);
    chk("poke_no_load_done", ld_cnt, 0);
    finish_mm(5);
    end_of_load_checks();

    // Reset after 600 A bytes, then a fresh full load
    clear_counts();
    send_load(1'b0, 1'b0, 600);
    nrst = 1'b0;
    #2;
    reset_value_checks("mid_rst");
    @(posedge clk); #1;
    nrst = 1'b1;
    clear_counts();
    @(posedge clk); #1;
    send_load(1'b0, 1'b0, 4 * B_WORDS + A_DEPTH);
    finish_mm(2);
    end_of_load_checks();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
